// File: rtl/seq_fixed_point_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_fixed_point_div
// Description : Multi-cycle signed fixed-point divider, q = a / b.
//               Operands are signed Q(WII.WIF). The quotient is signed
//               Q(WOI.WOF), rounded half away from zero (ROUND=1) or
//               truncated toward zero (ROUND=0), and saturated with flags.
//               Restoring division, one quotient bit per clock, fixed
//               latency independent of operand values.
// Ports       : clk        - clock, rising edge
//               rstn       - asynchronous active-low reset
//               i_valid    - operands present
//               i_ready    - idle, operands accepted on i_valid & i_ready
//               i_a, i_b   - dividend / divisor, signed Q(WII.WIF)
//               o_valid    - result valid, held until taken
//               o_ready    - consumer accepts on o_valid & o_ready
//               o_q        - quotient, signed Q(WOI.WOF)
//               o_upflow   - positive saturation (incl. x/0 with x >= 0)
//               o_downflow - negative saturation (incl. x/0 with x < 0)
//               o_divzero  - divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_fixed_point_div #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [WII+WIF-1:0] i_a,
  input  logic [WII+WIF-1:0] i_b,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [WOI+WOF-1:0] o_q,
  output logic               o_upflow,
  output logic               o_downflow,
  output logic               o_divzero
);

  localparam int WI   = WII + WIF;
  localparam int WO   = WOI + WOF;
  // One extra iteration produces the bit below the output LSB (round bit).
  localparam int N    = WI + WOF + 1;
  // Comparison width wide enough for both the N-bit magnitude and the
  // output range, plus one bit of headroom.
  localparam int CW   = ((N > WO) ? N : WO) + 1;
  localparam int CNTW = $clog2(N);

  localparam logic [CNTW-1:0] c_last   = CNTW'(N - 1);
  localparam logic [CW-1:0]   c_half   = {{(CW-1){1'b0}}, 1'b1} << (WO - 1);
  localparam logic [CW-1:0]   c_pmax   = c_half - {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WO-1:0]   c_q_max  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]   c_q_min  = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_divzero;
  logic [WI-1:0]   r_mag_b;
  logic [N-1:0]    r_num;
  logic [WI-1:0]   r_rem;
  logic [N-1:0]    r_quo;
  logic [CNTW-1:0] r_cnt;

  logic [WI-1:0]   w_abs_a;
  logic [WI-1:0]   w_abs_b;
  logic [WI:0]     w_rem_sh;
  logic            w_qbit;
  logic [WI-1:0]   w_rem_nx;
  logic [N-1:0]    w_mag;
  logic [CW-1:0]   w_mag_x;
  logic [WO-1:0]   w_q_lo;
  logic            w_neg;
  logic [WO-1:0]   w_q_res;
  logic            w_up;
  logic            w_dn;

  // Magnitudes are held unsigned in WI bits, so |min| is representable.
  assign w_abs_a = i_a[WI-1] ? -i_a : i_a;
  assign w_abs_b = i_b[WI-1] ? -i_b : i_b;

  // ---------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------
  assign w_rem_sh = {r_rem, r_num[N-1]};
  assign w_qbit   = (w_rem_sh >= {1'b0, r_mag_b});
  // After a subtraction the remainder is below |b| <= 2^(WI-1), so the
  // low WI bits hold it exactly. With a zero divisor the value wraps, which
  // is harmless because the result is overridden.
  assign w_rem_nx = w_qbit ? (w_rem_sh[WI-1:0] - r_mag_b) : w_rem_sh[WI-1:0];

  // ---------------------------------------------------------------------
  // Rounding and saturation of the raw quotient M = r_quo
  // ---------------------------------------------------------------------
  // (M+1)>>1 == (M>>1) + M[0]; this form cannot overflow N bits.
  assign w_mag   = {1'b0, r_quo[N-1:1]}
                 + {{(N-1){1'b0}}, ((ROUND != 0) & r_quo[0])};
  assign w_mag_x = {{(CW-N){1'b0}}, w_mag};
  assign w_q_lo  = w_mag_x[WO-1:0];
  assign w_neg   = r_sign_a ^ r_sign_b;

  always_comb begin
    w_q_res = w_q_lo;
    w_up    = 1'b0;
    w_dn    = 1'b0;
    if (r_divzero) begin
      if (r_sign_a) begin
        w_q_res = c_q_min;
        w_dn    = 1'b1;
      end else begin
        w_q_res = c_q_max;
        w_up    = 1'b1;
      end
    end else if (!w_neg) begin
      if (w_mag_x > c_pmax) begin
        w_q_res = c_q_max;
        w_up    = 1'b1;
      end
    end else begin
      // A magnitude of exactly 2^(WO-1) negates to min without a flag.
      if (w_mag_x > c_half) begin
        w_q_res = c_q_min;
        w_dn    = 1'b1;
      end else begin
        w_q_res = -w_q_lo;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    i_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_next = S_CALC;
      end
      S_CALC: begin
        if (r_cnt == c_last) w_next = S_FIN;
      end
      S_FIN: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_divzero  <= 1'b0;
      r_mag_b    <= '0;
      r_num      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      o_q        <= '0;
      o_upflow   <= 1'b0;
      o_downflow <= 1'b0;
      o_divzero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_sign_a  <= i_a[WI-1];
            r_sign_b  <= i_b[WI-1];
            r_divzero <= (i_b == '0);
            r_mag_b   <= w_abs_b;
            r_num     <= {w_abs_a, {(WOF+1){1'b0}}};
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[N-2:0], w_qbit};
          r_num <= {r_num[N-2:0], 1'b0};
          r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
        S_FIN: begin
          o_q        <= w_q_res;
          o_upflow   <= w_up;
          o_downflow <= w_dn;
          o_divzero  <= r_divzero;
        end
        S_OUT: begin
          // o_q keeps its last value after the result is taken.
          if (o_ready) begin
            o_upflow   <= 1'b0;
            o_downflow <= 1'b0;
            o_divzero  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_fixed_point_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_fixed_point_div
// Description : Directed self-checking bench for seq_fixed_point_div with
//               default parameters. A second instance with ROUND=0 shares
//               the stimulus to cover the truncating mode.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_fixed_point_div;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;

  logic        i_ready,   o_valid,   o_upflow,   o_downflow,   o_divzero;
  logic        i_ready_t, o_valid_t, o_upflow_t, o_downflow_t, o_divzero_t;
  logic [15:0] o_q, o_q_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_fixed_point_div #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROUND(1)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready),
    .o_q(o_q), .o_upflow(o_upflow), .o_downflow(o_downflow),
    .o_divzero(o_divzero)
  );

  seq_fixed_point_div #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROUND(0)) dut_t (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready_t),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid_t), .o_ready(o_ready),
    .o_q(o_q_t), .o_upflow(o_upflow_t), .o_downflow(o_downflow_t),
    .o_divzero(o_divzero_t)
  );

  // Present operands for exactly one (accepting) edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge until o_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: i_ready=%b o_valid=%b, required 1 0", i_ready, o_valid);
    end
    n_checks++;
    if (o_q !== 16'h0000 || {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: o_q=%h flags=%b, required 0000 000", o_q, {o_upflow, o_downflow, o_divzero});
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    issue(16'h0300, 16'h0200);
    wait_result(lat);
    n_checks++;
    if (lat !== 26) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, required 26", lat);
    end
    n_checks++;
    if (o_q !== 16'h0180 || {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_result: o_q=%h flags=%b, required 0180 000", o_q, {o_upflow, o_downflow, o_divzero});
    end
    n_checks++;
    if (i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: i_ready=%b, required 0", i_ready);
    end
    take();
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_q !== 16'h0180) begin
      n_fail++;
      $display("FAIL basic_take: o_valid=%b i_ready=%b o_q=%h, required 0 1 0180", o_valid, i_ready, o_q);
    end
  endtask

  task automatic test_sign_round();
    int lat;
    issue(16'hFD00, 16'h0200);
    wait_result(lat);
    n_checks++;
    if (lat !== 26 || o_q !== 16'hFE80 || {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL neg_result: lat=%0d o_q=%h flags=%b, required 26 FE80 000", lat, o_q, {o_upflow, o_downflow, o_divzero});
    end
    take();
    issue(16'h0001, 16'h0200);
    wait_result(lat);
    n_checks++;
    if (o_q !== 16'h0001) begin
      n_fail++;
      $display("FAIL round_half_up: o_q=%h, required 0001", o_q);
    end
    n_checks++;
    if (o_valid_t !== 1'b1 || o_q_t !== 16'h0000) begin
      n_fail++;
      $display("FAIL truncate: o_valid=%b o_q=%h, required 1 0000", o_valid_t, o_q_t);
    end
    take();
  endtask

  task automatic test_saturation();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vq [3];
    logic [2:0]  vf [3];
    int lat;
    va[0] = 16'h6400; vb[0] = 16'h0080; vq[0] = 16'h7FFF; vf[0] = 3'b100;
    va[1] = 16'h8000; vb[1] = 16'h0100; vq[1] = 16'h8000; vf[1] = 3'b000;
    va[2] = 16'h8000; vb[2] = 16'hFF00; vq[2] = 16'h7FFF; vf[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i]);
      wait_result(lat);
      n_checks++;
      if (lat !== 26 || o_q !== vq[i] || {o_upflow, o_downflow, o_divzero} !== vf[i]) begin
        n_fail++;
        $display("FAIL saturation[%0d]: lat=%0d o_q=%h flags=%b, required 26 %h %b", i, lat, o_q, {o_upflow, o_downflow, o_divzero}, vq[i], vf[i]);
      end
      take();
    end
  endtask

  task automatic test_divzero();
    logic [15:0] va [2];
    logic [15:0] vq [2];
    logic [2:0]  vf [2];
    int lat;
    va[0] = 16'hFD00; vq[0] = 16'h8000; vf[0] = 3'b011;
    va[1] = 16'h0100; vq[1] = 16'h7FFF; vf[1] = 3'b101;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], 16'h0000);
      wait_result(lat);
      n_checks++;
      if (lat !== 26 || o_q !== vq[i] || {o_upflow, o_downflow, o_divzero} !== vf[i]) begin
        n_fail++;
        $display("FAIL divzero[%0d]: lat=%0d o_q=%h flags=%b, required 26 %h %b", i, lat, o_q, {o_upflow, o_downflow, o_divzero}, vq[i], vf[i]);
      end
      take();
      n_checks++;
      if ({o_upflow, o_downflow, o_divzero} !== 3'b000 || o_q !== vq[i]) begin
        n_fail++;
        $display("FAIL divzero_clear[%0d]: o_q=%h flags=%b, required %h 000", i, o_q, {o_upflow, o_downflow, o_divzero}, vq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h6400, 16'h0080);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_a     = 16'(i * 16'h0123);
      i_b     = 16'h0100;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_q !== 16'h7FFF ||
          {o_upflow, o_downflow, o_divzero} !== 3'b100) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: o_valid=%b i_ready=%b o_q=%h flags=%b, required 1 0 7FFF 100", i, o_valid, i_ready, o_q, {o_upflow, o_downflow, o_divzero});
      end
    end
    i_valid = 1'b0;
    take();
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_q !== 16'h7FFF ||
        {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL backpressure_release: o_valid=%b i_ready=%b o_q=%h flags=%b, required 0 1 7FFF 000", o_valid, i_ready, o_q, {o_upflow, o_downflow, o_divzero});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    issue(16'h0300, 16'h0200);
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_q !== 16'h0000 ||
        {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: o_valid=%b i_ready=%b o_q=%h flags=%b, required 0 1 0000 000", o_valid, i_ready, o_q, {o_upflow, o_downflow, o_divzero});
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: o_valid seen=%b, required 0", seen);
    end
    issue(16'h0300, 16'h0200);
    wait_result(lat);
    n_checks++;
    if (lat !== 26 || o_q !== 16'h0180 || {o_upflow, o_downflow, o_divzero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_fresh: lat=%0d o_q=%h flags=%b, required 26 0180 000", lat, o_q, {o_upflow, o_downflow, o_divzero});
    end
    take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_round();
    test_saturation();
    test_divzero();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_fixed_point_div.md
Name: seq_fixed_point_div

Overview:
Multi-cycle signed fixed-point divider with valid/ready handshakes on both sides. Computes q = a/b for two signed Q(WII.WIF) operands. Produces a rounded, saturated signed Q(WOI.WOF) quotient with overflow flags. Sits directly upstream of the combinational fixed-point format converter, whose upflow/downflow and rounding rules it matches closely.

Parameters:
WII, 8, integer bits of dividend and divisor (including sign), >=2
WIF, 8, fraction bits of dividend and divisor, >=0
WOI, 8, integer bits of quotient (including sign), >=2
WOF, 8, fraction bits of quotient, >=0
ROUND, 1, 1 = round magnitude half away from zero; 0 = truncate magnitude toward zero

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
i_valid  in  1  operands present
i_ready  out  1  block idle, operands accepted on i_valid&i_ready
i_a  in  WII+WIF  dividend, signed Q(WII.WIF)
i_b  in  WII+WIF  divisor, signed Q(WII.WIF)
o_valid  out  1  result valid, held until taken
o_ready  in  1  consumer accepts on o_valid&o_ready
o_q  out  WOI+WOF  quotient, signed Q(WOI.WOF)
o_upflow  out  1  positive saturation occurred (includes divide-by-zero with a>=0)
o_downflow  out  1  negative saturation occurred (includes divide-by-zero with a<0)
o_divzero  out  1  divisor was zero

Behaviour:
- Reset (rstn low, async): state=IDLE; i_ready=1; o_valid=0; o_q=0; all flags 0; iteration counter 0.
- N = WII+WIF+WOF+1 iterations (last iteration yields the round bit).
- States: IDLE, CALC, FIN, OUT.
- IDLE: i_ready=1. On edge with i_valid=1:
  - latch sign_a, sign_b, |a|, |b|, divzero=(b==0);
  - numerator = |a| << (WOF+1), width WII+WIF+WOF+1; remainder=0; cnt=0;
  - go to CALC.
  - |min| fits because magnitudes are held unsigned in WII+WIF bits.
- CALC: restoring division, one quotient bit per edge, MSB first.
  - Shift remainder left, bringing in the next numerator bit.
  - If remainder >= |b|: subtract and set bit.
  - After N edges, go to FIN.
  - Fixed latency: iterations run even when divzero=1.
- FIN (one edge):
  - M = raw quotient = floor(|a|*2^(WOF+1)/|b|).
  - mag = ROUND ? (M+1)>>1 : M>>1.
  - neg = sign_a ^ sign_b.
  - Positive result: mag > 2^(WOI+WOF-1)-1 → o_q = max (0 followed by all 1s), o_upflow=1.
  - Negative result: mag > 2^(WOI+WOF-1) → o_q = min (1 followed by all 0s), o_downflow=1; otherwise o_q = -mag in two's complement. mag=2^(WOI+WOF-1) exactly gives min with no flag.
  - mag==0 gives o_q=0 with no flag, regardless of sign.
  - Divide-by-zero overrides all of the above: o_divzero=1. sign_a=0 → max, o_upflow=1; sign_a=1 → min, o_downflow=1.
  - Go to OUT with o_valid=1.
- Latency: o_valid rises on the (N+1)th edge after the accepting edge (26 for defaults).
- OUT:
  - o_valid=1; o_q and flags held stable while o_ready=0.
  - On edge with o_ready=1: o_valid=0, flags cleared, o_q holds its last value, go to IDLE.
  - i_ready is not asserted in the same cycle; throughput is one result per N+3 cycles minimum.
- i_ready=0 in CALC/FIN/OUT; i_a/i_b are ignored there and may change freely.
- Arithmetic widths:
  - remainder needs WII+WIF+1 bits;
  - quotient register is N bits;
  - the mag comparison uses N bits, so there is no intermediate truncation.
- Reset mid-operation (any state): immediate return to reset values; partial results are discarded and no o_valid pulse follows.

Test Plan:
1. Defaults, a=0x0300 (3.0), b=0x0200 (2.0) → o_q=0x0180, no flags, o_valid exactly 26 edges after acceptance.
2. a=0xFD00 (-3.0), b=0x0200 → o_q=0xFE80. a=0x0001, b=0x0200 → o_q=0x0001 with ROUND=1, 0x0000 with ROUND=0.
3. Saturation:
   - a=0x6400 (100.0), b=0x0080 (0.5) → o_q=0x7FFF, o_upflow=1.
   - a=0x8000, b=0x0100 → o_q=0x8000, no flag (boundary).
   - a=0x8000, b=0xFF00 → o_q=0x7FFF, o_upflow=1.
4. Divide-by-zero:
   - a=0xFD00, b=0 → o_q=0x8000, o_downflow=1, o_divzero=1.
   - a=0x0100, b=0 → o_q=0x7FFF, o_upflow=1, o_divzero=1.
   - Both with the same 26-edge latency.
5. Backpressure: hold o_ready=0 for 10 cycles after o_valid → o_q/flags stable, i_ready=0, new i_valid ignored; o_ready=1 → o_valid drops next edge, i_ready=1.
6. Assert rstn low mid-CALC → outputs are at reset values immediately; after release, a fresh 0x0300/0x0200 transaction yields 0x0180 with correct latency.
